// File: rtl/meter_pkg.sv
// Shared constants, FSM state encodings and the 7-segment decoder
// for the parking-meter display path.
package meter_pkg;

  // Largest time value the meter can show; anything above is clamped.
  localparam int          MAX_COUNT = 9999;
  localparam logic [13:0] MAX_BIN   = 14'(MAX_COUNT);

  // Number of multiplexed display digits.
  localparam int DIGITS = 4;

  // Default boundary for the slow "low time" blink.
  localparam int LOW_THRESH_DEFAULT = 180;

  // Conversion FSM encodings.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/meter_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/adjust step per cycle,
// 14 steps for a 14-bit input, then a single LOAD cycle that flags the
// result as ready. The caller decides when to start via 'start'.
module bin2bcd_seq
  import meter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic [13:0] bin_out
);

  logic [1:0]  state;
  logic [3:0]  shift_cnt;
  logic [13:0] bin_shift;
  logic [13:0] bin_cap;
  logic [15:0] scratch;
  logic [15:0] scratch_adj;

  assign done    = (state == LOAD);
  assign bcd     = scratch;
  assign bin_out = bin_cap;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture in IDLE, shift 14 times in CONV, hand off in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_cnt <= '0;
      bin_shift <= '0;
      bin_cap   <= '0;
      scratch   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_cap   <= bin_in;
            bin_shift <= bin_in;
            scratch   <= '0;
            shift_cnt <= '0;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          {scratch, bin_shift} <= {scratch_adj, bin_shift} << 1;
          shift_cnt            <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd13) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/meter_display.sv
// Parking-meter display: converts the binary seconds count to BCD,
// applies the low-time / expired blink rules and scans the four digits
// onto an active-low 7-segment display.
module meter_display
  import meter_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int REFRESH_DIV = 100_000,
  parameter int LOW_THRESH  = LOW_THRESH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] bcount,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int HALF_SEC = CLK_FREQ / 2;
  localparam int HALF_W   = (HALF_SEC > 1) ? $clog2(HALF_SEC) : 1;
  localparam int SCAN_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_SEC - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
  localparam logic [13:0]       LOW_BIN   = 14'(LOW_THRESH);

  logic [13:0]       bcount_clamped;
  logic [13:0]       last_bin;
  logic              conv_start;
  logic              conv_done;
  logic [15:0]       conv_bcd;
  logic [13:0]       conv_bin;
  logic [HALF_W-1:0] half_cnt;
  logic [1:0]        phase;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic [3:0]        nibble;
  logic              show;

  assign bcount_clamped = (bcount > MAX_BIN) ? MAX_BIN : bcount;
  assign conv_start     = (bcount_clamped != last_bin);
  assign dp             = 1'b1;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start),
    .bin_in  (bcount_clamped),
    .busy    (busy),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .bin_out (conv_bin)
  );

  // Publish a finished conversion: displayed digits and their value move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd      <= '0;
      last_bin <= '0;
    end else if (conv_done) begin
      bcd      <= conv_bcd;
      last_bin <= conv_bin;
    end
  end

  // Half-second tick drives a free-running 2-bit blink phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_cnt <= '0;
      phase    <= '0;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= '0;
      phase    <= phase + 2'd1;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  // Digit scan: hold each digit for REFRESH_DIV cycles, then move to the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink rule from the displayed value: fast when expired, slow when low.
  always_comb begin
    show = 1'b1;
    if (last_bin == '0) begin
      show = ~phase[0];
    end else if (last_bin < LOW_BIN) begin
      show = ~phase[1];
    end
  end

  // Pick the nibble belonging to the digit currently being scanned.
  always_comb begin
    nibble = bcd[{digit_idx, 2'b00} +: 4];
  end

  // Register enable and segments together so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else if (show) begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= seg_decode(nibble);
    end else begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end
  end

endmodule

// File: tb/tb_meter_display.sv
// Directed bench for meter_display with shortened blink and scan periods.
module tb_meter_display;

  logic        clk;
  logic        reset;
  logic [13:0] bcount;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] bcd;
  logic        busy;

  int total = 0;
  int bad   = 0;

  meter_display #(
    .CLK_FREQ    (40),
    .REFRESH_DIV (4),
    .LOW_THRESH  (180)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bcount (bcount),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .bcd    (bcd),
    .busy   (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic wait_bcd(input string tag, input logic [15:0] expected);
    int n = 0;
    while (bcd !== expected && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, bcd, expected);
  endtask

  task automatic wait_an_slot(input string tag, input logic [3:0] target);
    int n = 0;
    while (an === target && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (an !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 16'(an), 16'(target));
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    bcount = 14'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_an",   16'(an),   16'h000F);
    check_output("rst_seg",  16'(seg),  16'h007F);
    check_output("rst_dp",   16'(dp),   16'h0001);
    check_output("rst_bcd",  bcd,       16'h0000);
    check_output("rst_busy", 16'(busy), 16'h0000);

    // Expired: 20 cycles "0000", 20 cycles blank
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_output("zero_on_an",  16'(an),  16'h000B);
    check_output("zero_on_seg", 16'(seg), 16'h0040);
    repeat (20) @(negedge clk);
    check_output("zero_off_an",  16'(an),  16'h000F);
    check_output("zero_off_seg", 16'(seg), 16'h007F);
    repeat (20) @(negedge clk);
    check_output("zero_on2_an",  16'(an),  16'h000E);
    check_output("zero_on2_seg", 16'(seg), 16'h0040);

    // 0 -> 1234: latency and scan order
    bcount = 14'd1234;
    @(negedge clk);
    check_output("conv_busy", 16'(busy), 16'h0001);
    repeat (14) @(negedge clk);
    check_output("conv_bcd_early", bcd, 16'h0000);
    @(negedge clk);
    check_output("conv_bcd_16", bcd, 16'h1234);
    check_output("conv_busy_low", 16'(busy), 16'h0000);
    wait_an_slot("scan_an0", 4'b1110);
    check_output("scan_seg0", 16'(seg), 16'h0019);
    repeat (4) @(negedge clk);
    check_output("scan_an1",  16'(an),  16'h000D);
    check_output("scan_seg1", 16'(seg), 16'h0030);
    repeat (4) @(negedge clk);
    check_output("scan_an2",  16'(an),  16'h000B);
    check_output("scan_seg2", 16'(seg), 16'h0024);
    repeat (4) @(negedge clk);
    check_output("scan_an3",  16'(an),  16'h0007);
    check_output("scan_seg3", 16'(seg), 16'h0079);

    // Low time: 40 on / 40 off, then 180 is steady
    bcount = 14'd179;
    wait_bcd("low_bcd", 16'h0179);
    n = 0;
    while (an === 4'hF && n < 200) begin @(negedge clk); n++; end
    while (an !== 4'hF && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (an === 4'hF && n < 200) begin @(negedge clk); n++; end
    check_output("low_blank_len", 16'(n), 16'd40);
    n = 0;
    while (an !== 4'hF && n < 200) begin @(negedge clk); n++; end
    check_output("low_on_len", 16'(n), 16'd40);
    bcount = 14'd180;
    wait_bcd("thr_bcd", 16'h0180);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (an === 4'hF) n++;
      @(negedge clk);
    end
    check_output("thr_blank_cnt", 16'(n), 16'd0);

    // Maximum and clamp
    bcount = 14'd9999;
    wait_bcd("max_bcd", 16'h9999);
    bcount = 14'h3FFF;
    repeat (40) @(negedge clk);
    check_output("clamp_bcd", bcd, 16'h9999);

    // Change during conversion is picked up afterwards
    bcount = 14'd500;
    repeat (5) @(negedge clk);
    bcount = 14'd600;
    wait_bcd("mid_first", 16'h0500);
    @(negedge clk);
    check_output("mid_busy_again", 16'(busy), 16'h0001);
    wait_bcd("mid_second", 16'h0600);

    // Reset in the middle of a conversion
    bcount = 14'd500;
    repeat (6) @(negedge clk);
    check_output("rstc_busy_pre", 16'(busy), 16'h0001);
    reset = 1'b1;
    @(negedge clk);
    check_output("rstc_busy", 16'(busy), 16'h0000);
    check_output("rstc_bcd",  bcd,       16'h0000);
    check_output("rstc_an",   16'(an),   16'h000F);
    reset = 1'b0;
    wait_bcd("rstc_reconv", 16'h0500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
